count_driver: RTL and testbench
===============================

COUNT_DRIVER -- requirements
Module: count_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 16, count width in bits.
REQ-002 SHALL have parameter TARGET, default 20, terminal count value (0 .. 2^WIDTH-1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a count run.
REQ-006 SHALL have port en  input  1  count-advance qualifier while running.
REQ-007 SHALL have port abort  input  1  terminate the current run immediately.
REQ-008 SHALL have port count  output  WIDTH  current count value, registered.
REQ-009 SHALL have port below_target  output  1  high while count < TARGET, registered; drives counter-reset/enable switching downstream.
REQ-010 SHALL have port busy  output  1  high in RUN state.
REQ-011 SHALL have port done  output  1  one-cycle pulse on run completion.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL, in IDLE with start=1 and abort=0, clear count to 0 and enter RUN next cycle.
REQ-014 SHALL, in RUN, increment count by 1 on each cycle with en=1; hold count when en=0.
REQ-015 SHALL enter DONE on the cycle count reaches TARGET (increment landing on TARGET); count holds TARGET.
REQ-016 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-017 SHALL, with TARGET=0, go IDLE -> DONE directly on start (no RUN cycle), count=0.
REQ-018 SHALL ignore start while in RUN or DONE.
REQ-019 SHALL, on abort=1 in RUN, return to IDLE next cycle, hold count, not pulse done.
REQ-020 SHALL give abort priority over start when both are high in IDLE (stay IDLE).
REQ-021 SHALL never let count exceed TARGET; no wrap-around in any state.
REQ-022 SHALL update below_target with the same-cycle latency as count (both registered; below_target reflects next count value).
REQ-023 SHALL compute below_target as unsigned comparison count < TARGET at WIDTH bits.
REQ-024 SHALL keep busy = (state == RUN) registered, asserted the cycle after accepted start.

Reset
REQ-025 SHALL on rst_n=0 force state IDLE, count=0, busy=0, done=0, below_target=1 (0 if TARGET=0), asynchronously.
REQ-026 SHALL, on reset mid-run, discard the run with no done pulse; resume on next start after rst_n deasserts.

Configuration
REQ-027 SHALL use macro COUNT_DRIVER_AUTORELOAD_EN.
REQ-028 SHALL, with macro defined, go DONE -> RUN (count cleared to 0) instead of DONE -> IDLE, repeating until abort; done pulses once per completed run.
REQ-029 SHALL, with macro undefined, behave per REQ-016 only; no reload logic present.

Structure
REQ-030 SHALL place state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default WIDTH constant in shared package count_pkg.
REQ-031 SHALL instantiate one sub-module count_cmp (registered less-than comparator, parameter TARGET) producing below_target.

Verification
REQ-032 SHALL cover: TARGET=20, start, en=1 continuous -> busy 1 cycle after start, count 0..20, done pulse when count=20, below_target falls same cycle count=20, IDLE next.
REQ-033 SHALL cover: en toggled 1/0 every cycle, TARGET=20 -> done arrives 40 cycles (±1) after busy rises, count never skips or exceeds 20.
REQ-034 SHALL cover: abort at count=7 -> IDLE next cycle, count holds 7, no done; start+abort together in IDLE -> stays IDLE.
REQ-035 SHALL cover: rst_n low at count=12 -> count=0, busy=0, below_target=1 immediately (async), no done.
REQ-036 SHALL cover: TARGET=0 -> start yields done next cycle, count=0, busy never asserted.
REQ-037 SHALL cover: COUNT_DRIVER_AUTORELOAD_EN defined, TARGET=5 -> done every 6 cycles with en=1 until abort, count cycles 0..5.

Source files
------------

// File: rtl/count_pkg.sv
// ============================================================================
// Module      : count_pkg
// Description : Shared state encoding and defaults for the count_driver block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package count_pkg;

    localparam int unsigned c_width_default = 16;

    typedef logic [1:0] state_t;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

endpackage : count_pkg

`default_nettype wire

// File: rtl/count_cmp.sv
// ============================================================================
// Module      : count_cmp
// Description : Registered unsigned less-than comparator against TARGET.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_cmp
    import count_pkg::*;
#(
    parameter int unsigned WIDTH  = c_width_default,
    parameter int unsigned TARGET = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] nxt_count,
    output logic             below_target
);

    localparam logic [WIDTH-1:0] c_target = WIDTH'(TARGET);

    logic r_below;

    // Fed with the next count so the flag lines up with the registered count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_below <= (c_target != '0);
        end else begin
            r_below <= (nxt_count < c_target);
        end
    end

    assign below_target = r_below;

endmodule : count_cmp

`default_nettype wire

// File: rtl/count_driver.sv
// ============================================================================
// Module      : count_driver
// Description : Start/abort controlled up-counter that stops at TARGET and
//               pulses done. Define COUNT_DRIVER_AUTORELOAD_EN to restart a
//               new run automatically after each completion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_driver
    import count_pkg::*;
#(
    parameter int unsigned WIDTH  = c_width_default,
    parameter int unsigned TARGET = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             below_target,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] c_target   = WIDTH'(TARGET);
    localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);
    localparam logic             c_tgt_zero = (c_target == '0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_count_inc;
    logic             r_busy;
    logic             r_done;

    assign w_count_inc = r_count + c_one;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            c_idle: begin
                if (start && !abort) begin
                    w_count_nxt = '0;
                    w_state_nxt = c_tgt_zero ? c_done : c_run;
                end
            end
            c_run: begin
                // RUN is only ever entered below TARGET, so the increment can
                // land on TARGET but never pass it.
                if (abort) begin
                    w_state_nxt = c_idle;
                end else if (en) begin
                    w_count_nxt = w_count_inc;
                    if (w_count_inc == c_target) begin
                        w_state_nxt = c_done;
                    end
                end
            end
            c_done: begin
`ifdef COUNT_DRIVER_AUTORELOAD_EN
                if (abort) begin
                    w_state_nxt = c_idle;
                end else begin
                    w_count_nxt = '0;
                    w_state_nxt = c_tgt_zero ? c_done : c_run;
                end
`else
                w_state_nxt = c_idle;
`endif
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_busy  <= (w_state_nxt == c_run);
            r_done  <= (w_state_nxt == c_done);
        end
    end

    count_cmp #(
        .WIDTH  (WIDTH),
        .TARGET (TARGET)
    ) u_cmp (
        .clk          (clk),
        .rst_n        (rst_n),
        .nxt_count    (w_count_nxt),
        .below_target (below_target)
    );

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule : count_driver

`default_nettype wire

// File: tb/tb_count_driver.sv
// ============================================================================
// Module      : tb_count_driver
// Description : Self-checking bench for count_driver (TARGET 20, 0 and 5).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_driver;

`ifdef COUNT_DRIVER_AUTORELOAD_EN
    localparam bit c_reload = 1'b1;
`else
    localparam bit c_reload = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic start;
    logic en;
    logic abort;

    logic [15:0] cnt20;
    logic        below20, busy20, done20;
    logic [7:0]  cnt0;
    logic        below0, busy0, done0;
    logic [3:0]  cnt5;
    logic        below5, busy5, done5;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one run descriptor per DUT
    int tgt   [3] = '{20, 0, 5};
    int m_cnt [3];
    bit m_run [3];
    bit m_fin [3];

    count_driver #(.WIDTH(16), .TARGET(20)) dut20 (
        .clk(clk), .rst_n(rst_n), .start(start), .en(en), .abort(abort),
        .count(cnt20), .below_target(below20), .busy(busy20), .done(done20));

    count_driver #(.WIDTH(8), .TARGET(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .en(en), .abort(abort),
        .count(cnt0), .below_target(below0), .busy(busy0), .done(done0));

    count_driver #(.WIDTH(4), .TARGET(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start), .en(en), .abort(abort),
        .count(cnt5), .below_target(below5), .busy(busy5), .done(done5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_run[i] = 1'b0;
            m_fin[i] = 1'b0;
        end
    endfunction

    function automatic void model_step(int i);
        if (m_fin[i]) begin
            m_fin[i] = 1'b0;
            if (c_reload && !abort) begin
                m_cnt[i] = 0;
                if (tgt[i] == 0) m_fin[i] = 1'b1;
                else             m_run[i] = 1'b1;
            end
        end else if (m_run[i]) begin
            if (abort) begin
                m_run[i] = 1'b0;
            end else if (en) begin
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == tgt[i]) begin
                    m_run[i] = 1'b0;
                    m_fin[i] = 1'b1;
                end
            end
        end else if (start && !abort) begin
            m_cnt[i] = 0;
            if (tgt[i] == 0) m_fin[i] = 1'b1;
            else             m_run[i] = 1'b1;
        end
    endfunction

    function automatic longint get_cnt(int i);
        case (i)
            0:       return longint'(cnt20);
            1:       return longint'(cnt0);
            default: return longint'(cnt5);
        endcase
    endfunction

    function automatic logic get_flag(int i, int which);
        logic [2:0] f;
        case (i)
            0:       f = {below20, busy20, done20};
            1:       f = {below0, busy0, done0};
            default: f = {below5, busy5, done5};
        endcase
        return f[which];
    endfunction

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("count_t%0d", tgt[i]), get_cnt(i), m_cnt[i]);
            chk($sformatf("below_t%0d", tgt[i]), get_flag(i, 2), (m_cnt[i] < tgt[i]) ? 1 : 0);
            chk($sformatf("busy_t%0d", tgt[i]), get_flag(i, 1), m_run[i]);
            chk($sformatf("done_t%0d", tgt[i]), get_flag(i, 0), m_fin[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic go_idle();
        start = 1'b0;
        en    = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin : main
        int n;
        int prev;
        rst_n = 1'b0;
        start = 1'b0;
        en    = 1'b0;
        abort = 1'b0;
        model_reset();
        #12;
        compare_all();
        chk("rst_below_t0", below0, 0);
        rst_n = 1'b1;
        tick();

        // Continuous enable run to TARGET
        go_idle();
        start = 1'b1;
        en    = 1'b1;
        tick();
        start = 1'b0;
        chk("a_busy_after_start", busy20, 1);
        chk("a_count_start", cnt20, 0);
        chk("a_t0_done", done0, 1);
        chk("a_t0_busy", busy0, 0);
        n = 0;
        while (!done20 && n < 30) begin
            tick();
            n++;
        end
        chk("a_latency", n, 20);
        chk("a_count_at_done", cnt20, 20);
        chk("a_below_at_done", below20, 0);
        abort = c_reload;
        tick();
        abort = 1'b0;
        chk("a_idle_after_done", busy20, 0);

        // Enable toggling every cycle
        go_idle();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        prev = int'(cnt20);
        while (!done20 && n < 100) begin
            en = (n % 2 == 0);
            tick();
            n++;
            chk("b_step", ((int'(cnt20) - prev) <= 1 && int'(cnt20) <= 20) ? 1 : 0, 1);
            prev = int'(cnt20);
        end
        chk("b_latency_window", (n >= 39 && n <= 41) ? 1 : 0, 1);

        // Abort at count 7, then start+abort in idle
        go_idle();
        start = 1'b1;
        en    = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (cnt20 != 16'd7 && n < 30) begin
            tick();
            n++;
        end
        chk("c_reached7", cnt20, 7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("c_abort_busy", busy20, 0);
        chk("c_abort_count", cnt20, 7);
        chk("c_abort_done", done20, 0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("c_both_busy", busy20, 0);
        chk("c_both_done", done20, 0);

        // Reset mid-run at count 12
        go_idle();
        start = 1'b1;
        en    = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (cnt20 != 16'd12 && n < 30) begin
            tick();
            n++;
        end
        chk("d_reached12", cnt20, 12);
        async_reset();
        chk("d_rst_count", cnt20, 0);
        chk("d_rst_busy", busy20, 0);
        chk("d_rst_below", below20, 1);
        tick();
        chk("d_no_done", done20, 0);

        // TARGET=0 goes straight to completion
        go_idle();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("e_t0_done", done0, 1);
        chk("e_t0_count", cnt0, 0);
        chk("e_t0_busy", busy0, 0);

`ifdef COUNT_DRIVER_AUTORELOAD_EN
        // Auto-reload: TARGET=5 completes every 6 cycles
        go_idle();
        start = 1'b1;
        en    = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done5 && n < 20) begin
            tick();
            n++;
        end
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!done5 && n < 20);
            chk("f_reload_period", n, 6);
        end
        go_idle();
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 7) == 0);
            en    = ($urandom_range(0, 3) != 0);
            abort = ($urandom_range(0, 39) == 0);
            tick();
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_count_driver

`default_nettype wire
